// File: rtl/count_seq_arb.sv
// Round-robin controller for a shared interval-timer counter: clears it, enables it for len ticks, pulses done.
// Optional watchdog on the RUN phase is compiled in with `define COUNT_SEQ_TIMEOUT_EN.
module count_seq_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       grant_q;
  logic [1:0]       grant_nxt;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] len_nxt;
  logic             last_q;
  logic             last_nxt;
  logic             win;
  logic             match;
  logic             timeout;

  // Index of the winning requester; on a tie the one not served last wins.
  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    logic w;
    if (r == 2'b01)
      w = 1'b0;
    else if (r == 2'b10)
      w = 1'b1;
    else
      w = ~last;
    return w;
  endfunction

  assign match = (cnt_val == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      len_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      len_q   <= len_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    len_nxt   = len_q;
    last_nxt  = last_q;
    win       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    done      = 2'b00;
    case (state)
      IDLE: begin
        if (|req) begin
          win       = pick_winner(req, last_q);
          grant_nxt = win ? 2'b10 : 2'b01;
          len_nxt   = win ? len1 : len0;
          last_nxt  = win;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // Enable stops on the match cycle, giving exactly len_q enabled ticks.
        cnt_en = ~match;
        if (match || timeout)
          state_nxt = DONE;
      end
      DONE: begin
        done      = grant_q;
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

`ifdef COUNT_SEQ_TIMEOUT_EN
  localparam logic [WIDTH+1:0] WDOG_LAST = (WIDTH+2)'((2 ** WIDTH) + 1);
  localparam logic [WIDTH+1:0] WDOG_ONE  = (WIDTH+2)'(1);

  logic [WIDTH+1:0] wdog;
  logic             to_q;

  // A legal interval spends at most 2^WIDTH cycles in RUN, so cycle 2^WIDTH+2 means the counter is stuck.
  assign timeout = (state == RUN) && !match && (wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
      to_q <= 1'b0;
    end else begin
      if (state == RUN)
        wdog <= wdog + WDOG_ONE;
      else
        wdog <= '0;
      if (timeout)
        to_q <= 1'b1;
      else if (state == DONE)
        to_q <= 1'b0;
    end
  end

  assign err = to_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq_arb.sv
// Directed bench for count_seq_arb with a behavioural counter; table of transactions plus reset and timeout sequences.
// Define COUNT_SEQ_TIMEOUT_EN to exercise the watchdog build.
module tb_count_seq_arb;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] len0, len1;
  logic [W-1:0] cnt_val;
  logic         cnt_clr, cnt_en, busy, err;
  logic [1:0]   grant, done;

  logic [W-1:0] cnt = '0;
  bit           stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] l0;
    logic [W-1:0] l1;
    logic [1:0]   owner;
    int           n;
    bit           disturb;
    string        name;
  } vec_t;

  vec_t vecs[11];

  count_seq_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1),
    .cnt_val(cnt_val), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .grant(grant),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_clr)
      cnt <= '0;
    else if (cnt_en)
      cnt <= cnt + 1'b1;
  end
  assign cnt_val = stuck ? '0 : cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_clr"}, cnt_clr, 0);
    check({tag, "_en"}, cnt_en, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic run_vec(input int i);
    int edges, en_n, clr_n;
    bit grant_bad, both_bad, seen;
    @(negedge clk);
    req  = vecs[i].req;
    len0 = vecs[i].l0;
    len1 = vecs[i].l1;
    edges = 0; en_n = 0; clr_n = 0;
    grant_bad = 0; both_bad = 0; seen = 0;
    while (!seen && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (cnt_en) en_n++;
      if (cnt_clr) clr_n++;
      if (cnt_en && cnt_clr) both_bad = 1;
      if (grant != vecs[i].owner) grant_bad = 1;
      if (vecs[i].disturb && edges == 3) begin
        len0 = 4'd9;
        req  = 2'b11;
      end
      if (done != 2'b00) seen = 1;
    end
    check({vecs[i].name, "_done"}, done, vecs[i].owner);
    check({vecs[i].name, "_latency"}, edges - 1, vecs[i].n + 2);
    check({vecs[i].name, "_en_cycles"}, en_n, vecs[i].n);
    check({vecs[i].name, "_clr_cycles"}, clr_n, 1);
    check({vecs[i].name, "_grant_held"}, grant_bad, 0);
    check({vecs[i].name, "_clr_en_excl"}, both_bad, 0);
    check({vecs[i].name, "_err"}, err, 0);
    req = req & ~done;
    @(posedge clk); #1;
    check({vecs[i].name, "_pulse_end"}, done, 0);
    check({vecs[i].name, "_idle_busy"}, busy, 0);
    check({vecs[i].name, "_idle_grant"}, grant, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int edges, en_n;
    bit bad, seen;

    vecs[0]  = '{2'b11, 4'd3,  4'd2, 2'b01, 3,  1'b0, "tie_first"};
    vecs[1]  = '{2'b10, 4'd3,  4'd2, 2'b10, 2,  1'b0, "tie_second"};
    vecs[2]  = '{2'b11, 4'd3,  4'd2, 2'b01, 3,  1'b0, "rr_a"};
    vecs[3]  = '{2'b11, 4'd3,  4'd2, 2'b10, 2,  1'b0, "rr_b"};
    vecs[4]  = '{2'b11, 4'd3,  4'd2, 2'b01, 3,  1'b0, "rr_c"};
    vecs[5]  = '{2'b01, 4'd5,  4'd0, 2'b01, 5,  1'b0, "single5"};
    vecs[6]  = '{2'b10, 4'd0,  4'd0, 2'b10, 0,  1'b0, "zero_len"};
    vecs[7]  = '{2'b01, 4'd15, 4'd0, 2'b01, 15, 1'b0, "max_len"};
    vecs[8]  = '{2'b01, 4'd4,  4'd0, 2'b01, 4,  1'b1, "busy_ignore"};
    vecs[9]  = '{2'b10, 4'd4,  4'd7, 2'b10, 7,  1'b0, "after_busy"};
    vecs[10] = '{2'b11, 4'd2,  4'd6, 2'b01, 2,  1'b0, "post_reset"};

    rst_n = 1'b0; req = 2'b00; len0 = '0; len1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_release_busy", busy, 0);

    for (int i = 0; i < 10; i++)
      run_vec(i);

    // Reset asserted asynchronously during the 4th enabled cycle.
    @(negedge clk);
    req = 2'b01; len0 = 4'd10;
    edges = 0; en_n = 0;
    while (en_n < 4 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
      if (cnt_en) en_n++;
    end
    check("midrun_reached_en4", en_n, 4);
    rst_n = 1'b0;
    #1;
    check_quiet("midrun_reset");
    req = 2'b00;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done != 2'b00 || busy) bad = 1;
    end
    check("midrun_no_done", bad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(10);

    // Counter stuck at zero.
    stuck = 1'b1;
`ifdef COUNT_SEQ_TIMEOUT_EN
    @(negedge clk);
    req = 2'b01; len0 = 4'd5;
    edges = 0; seen = 0;
    while (!seen && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (done != 2'b00) seen = 1;
    end
    check("timeout_done", done, 2'b01);
    check("timeout_err", err, 1);
    check("timeout_latency", edges - 1, (2 ** W) + 3);
    req = 2'b00;
    @(posedge clk); #1;
    check("timeout_err_clear", err, 0);
    check("timeout_done_clear", done, 0);
    check("timeout_idle", busy, 0);
`else
    @(negedge clk);
    req = 2'b01; len0 = 4'd5;
    @(posedge clk); #1;
    bad = 0; seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!busy) bad = 1;
      if (err || done != 2'b00) seen = 1;
    end
    check("stuck_busy_held", bad, 0);
    check("stuck_no_err_done", seen, 0);
    check("stuck_grant", grant, 2'b01);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("stuck_reset");
    @(negedge clk);
    rst_n = 1'b1;
`endif
    stuck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
